// File: rtl/integrador_rampa.sv
// integrador_rampa
//   Dual-slope (ramp) integrator datapath for a dual-slope voltmeter.
//   A measurement has four phases:
//     IDLE  - the accumulator is held at zero until ch_vm starts a measurement.
//     INTEG - vin is added every cycle, saturating at full scale. The interval
//             ends on enb_3, after that cycle's addition.
//     DEINT - the reference step is subtracted every cycle. The step is vref,
//             or 1 when vref is zero.
//     DONE  - the accumulator has reached zero and Vint_z is raised. ch_vm
//             acknowledges the result and returns the block to IDLE.
//   All outputs are registered.
//
// Ports
//   clk     in   system clock, rising edge
//   reset   in   synchronous active-high reset
//   ch_vm   in   measurement start / acknowledge key
//   enb_3   in   end of the fixed integration interval (used only in INTEG)
//   vin     in   [W_IN]  unsigned unknown-voltage sample
//   vref    in   [W_IN]  unsigned reference-voltage magnitude
//   Vint_z  out  integrator-at-zero flag (high only in DONE)
//   vint    out  [W_ACC] accumulator value
//   phase   out  [2]     IDLE=00 INTEG=01 DEINT=10 DONE=11
//   ovf     out  sticky saturation flag, cleared when a new measurement starts
module integrador_rampa #(
  parameter int W_IN  = 8,
  parameter int W_ACC = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ch_vm,
  input  logic             enb_3,
  input  logic [W_IN-1:0]  vin,
  input  logic [W_IN-1:0]  vref,
  output logic             Vint_z,
  output logic [W_ACC-1:0] vint,
  output logic [1:0]       phase,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    INTEG = 2'b01,
    DEINT = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t           state, state_nxt;
  logic [W_ACC-1:0] vint_nxt;
  logic             vint_z_nxt;
  logic             ovf_nxt;
  logic [W_ACC:0]   sum_wide;
  logic [W_ACC-1:0] step;

  // One guard bit above the accumulator catches the carry out of the add.
  function automatic logic [W_ACC:0] add_wide(input logic [W_ACC-1:0] acc,
                                              input logic [W_IN-1:0]  x);
    return {1'b0, acc} + {{(W_ACC+1-W_IN){1'b0}}, x};
  endfunction

  // Clamp to full scale when the guard bit is set, so vint never wraps.
  function automatic logic [W_ACC-1:0] sat(input logic [W_ACC:0] s);
    return s[W_ACC] ? '1 : s[W_ACC-1:0];
  endfunction

  // A zero reference would stall de-integration; fall back to a unit step.
  function automatic logic [W_ACC-1:0] step_of(input logic [W_IN-1:0] r);
    return (r == '0) ? W_ACC'(1) : {{(W_ACC-W_IN){1'b0}}, r};
  endfunction

  assign sum_wide = add_wide(vint, vin);
  assign step     = step_of(vref);
  assign phase    = state;

  always_comb begin
    state_nxt  = state;
    vint_nxt   = vint;
    vint_z_nxt = Vint_z;
    ovf_nxt    = ovf;
    unique case (state)
      IDLE: begin
        vint_nxt   = '0;
        vint_z_nxt = 1'b0;
        // enb_3 is not looked at here, so a coincident enb_3 only starts
        // the measurement.
        if (ch_vm) begin
          state_nxt = INTEG;
          ovf_nxt   = 1'b0;
        end
      end
      INTEG: begin
        vint_nxt = sat(sum_wide);
        if (sum_wide[W_ACC]) ovf_nxt = 1'b1;
        if (enb_3) state_nxt = DEINT;
      end
      DEINT: begin
        if (vint > step) begin
          vint_nxt = vint - step;
        end else begin
          // The final partial step lands exactly on zero instead of going
          // below it.
          vint_nxt   = '0;
          vint_z_nxt = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        vint_nxt   = '0;
        vint_z_nxt = 1'b1;
        if (ch_vm) begin
          state_nxt  = IDLE;
          vint_z_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt  = IDLE;
        vint_nxt   = '0;
        vint_z_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      vint   <= '0;
      Vint_z <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_nxt;
      vint   <= vint_nxt;
      Vint_z <= vint_z_nxt;
      ovf    <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_integrador_rampa.sv
// tb_integrador_rampa
//   Directed bench for integrador_rampa using the default parameters
//   (W_IN=8, W_ACC=12). Expected values are worked out by hand from the
//   measurement arithmetic.
module tb_integrador_rampa;

  logic        clk = 1'b0;
  logic        reset;
  logic        ch_vm;
  logic        enb_3;
  logic [7:0]  vin;
  logic [7:0]  vref;
  logic        Vint_z;
  logic [11:0] vint;
  logic [1:0]  phase;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  integrador_rampa #(.W_IN(8), .W_ACC(12)) dut (
    .clk    (clk),
    .reset  (reset),
    .ch_vm  (ch_vm),
    .enb_3  (enb_3),
    .vin    (vin),
    .vref   (vref),
    .Vint_z (Vint_z),
    .vint   (vint),
    .phase  (phase),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int ph, input int v,
                         input int z, input int o);
    chk({tag, ".phase"},  32'(phase),  32'(ph));
    chk({tag, ".vint"},   32'(vint),   32'(v));
    chk({tag, ".Vint_z"}, 32'(Vint_z), 32'(z));
    chk({tag, ".ovf"},    32'(ovf),    32'(o));
  endtask

  initial begin
    reset = 1'b1; ch_vm = 1'b0; enb_3 = 1'b0; vin = 8'd0; vref = 8'd0;
    tick(); tick();
    chk_all("reset", 0, 0, 0, 0);
    reset = 1'b0;

    // IDLE holds without ch_vm.
    vin = 8'd20; vref = 8'd10;
    tick();
    chk_all("idle_hold", 0, 0, 0, 0);

    // ch_vm and enb_3 together in IDLE: only the start takes effect.
    ch_vm = 1'b1; enb_3 = 1'b1;
    tick();
    chk_all("start_both", 1, 0, 0, 0);
    ch_vm = 1'b0; enb_3 = 1'b0;

    // Normal measurement: 8 x 20 = 160, then 16 steps of 10.
    tick();
    chk("integ1.vint", 32'(vint), 32'd20);
    repeat (6) tick();
    chk_all("integ7", 1, 140, 0, 0);
    enb_3 = 1'b1;
    tick();
    chk_all("integ8", 2, 160, 0, 0);
    enb_3 = 1'b0;

    // De-integration with stray ch_vm / enb_3 pulses that must be ignored.
    for (int i = 1; i <= 15; i++) begin
      ch_vm = (i == 3 || i == 9);
      enb_3 = (i == 5 || i == 9);
      tick();
      chk("deint.vint",  32'(vint),  32'(160 - 10 * i));
      chk("deint.phase", 32'(phase), 32'd2);
    end
    ch_vm = 1'b0; enb_3 = 1'b0;
    tick();
    chk_all("deint16", 3, 0, 1, 0);
    tick();
    chk_all("done_hold", 3, 0, 1, 0);
    ch_vm = 1'b1;
    tick();
    chk_all("ack", 0, 0, 0, 0);
    ch_vm = 1'b0;

    // Saturation: 16 x 255 = 4080, 17th add clamps at 4095.
    vin = 8'd255; vref = 8'd255; ch_vm = 1'b1;
    tick();
    chk_all("sat_start", 1, 0, 0, 0);
    ch_vm = 1'b0;
    repeat (16) tick();
    chk_all("sat16", 1, 4080, 0, 0);
    enb_3 = 1'b1;
    tick();
    chk_all("sat17", 2, 4095, 0, 1);
    enb_3 = 1'b0;
    // 4095 - 16 x 255 = 15, then 15 <= 255 finishes.
    repeat (16) tick();
    chk_all("sat_deint16", 2, 15, 0, 1);
    tick();
    chk_all("sat_done", 3, 0, 1, 1);
    ch_vm = 1'b1;
    tick();
    chk_all("sat_ack", 0, 0, 0, 1);
    ch_vm = 1'b0;
    tick();
    chk_all("sat_idle", 0, 0, 0, 1);

    // Zero reference: 2 x 3 = 6, unit steps, done on 6th DEINT edge.
    vin = 8'd3; vref = 8'd0; ch_vm = 1'b1;
    tick();
    chk_all("zr_start", 1, 0, 0, 0);
    ch_vm = 1'b0;
    tick();
    chk("zr_integ1.vint", 32'(vint), 32'd3);
    enb_3 = 1'b1;
    tick();
    chk_all("zr_integ2", 2, 6, 0, 0);
    enb_3 = 1'b0;
    repeat (5) tick();
    chk_all("zr_deint5", 2, 1, 0, 0);
    tick();
    chk_all("zr_done", 3, 0, 1, 0);
    ch_vm = 1'b1;
    tick();
    chk_all("zr_ack", 0, 0, 0, 0);
    ch_vm = 1'b0;

    // vref changed mid-DEINT takes effect on the next edge: 10 -> 6 -> 1 -> 0.
    vin = 8'd10; vref = 8'd4; ch_vm = 1'b1;
    tick();
    ch_vm = 1'b0; enb_3 = 1'b1;
    tick();
    chk_all("vr_integ1", 2, 10, 0, 0);
    enb_3 = 1'b0;
    tick();
    chk("vr_step4.vint", 32'(vint), 32'd6);
    vref = 8'd5;
    tick();
    chk("vr_step5.vint", 32'(vint), 32'd1);
    tick();
    chk_all("vr_done", 3, 0, 1, 0);
    ch_vm = 1'b1;
    tick();
    ch_vm = 1'b0;
    chk_all("vr_ack", 0, 0, 0, 0);

    // Reset mid-DEINT at vint=50: aborted, no Vint_z afterwards.
    vin = 8'd10; vref = 8'd7; ch_vm = 1'b1;
    tick();
    ch_vm = 1'b0;
    repeat (4) tick();
    chk("rd_integ4.vint", 32'(vint), 32'd40);
    enb_3 = 1'b1;
    tick();
    chk_all("rd_integ5", 2, 50, 0, 0);
    enb_3 = 1'b0;
    reset = 1'b1;
    tick();
    chk_all("rd_reset", 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      enb_3 = i[0];
      tick();
      chk("rd_after.Vint_z", 32'(Vint_z), 32'd0);
      chk("rd_after.phase",  32'(phase),  32'd0);
    end
    enb_3 = 1'b0;

    // Reset mid-INTEG with ovf set clears ovf.
    vin = 8'd255; ch_vm = 1'b1;
    tick();
    ch_vm = 1'b0;
    repeat (18) tick();
    chk_all("ri_sat", 1, 4095, 0, 1);
    reset = 1'b1; ch_vm = 1'b1; enb_3 = 1'b1;
    tick();
    chk_all("ri_reset", 0, 0, 0, 0);
    reset = 1'b0; ch_vm = 1'b0; enb_3 = 1'b0;
    repeat (5) tick();
    chk_all("ri_after", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/integrador_rampa.md
INTEGRADOR_RAMPA -- requirements
Module: integrador_rampa

Interface
REQ-001 The block SHALL have parameter W_IN, default 8, meaning width of the input and reference samples.
REQ-002 The block SHALL have parameter W_ACC, default 12, meaning width of the integrator accumulator (W_ACC > W_IN).
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port ch_vm, input, 1 bit: measurement start / acknowledge key, the same signal the controller receives.
REQ-006 The block SHALL have port enb_3, input, 1 bit: end of the fixed integration interval.
REQ-007 The block SHALL have port vin, input, W_IN bits: unsigned unknown-voltage sample.
REQ-008 The block SHALL have port vref, input, W_IN bits: unsigned reference-voltage magnitude.
REQ-009 The block SHALL have port Vint_z, output, 1 bit: integrator-at-zero flag, consumed by the controller.
REQ-010 The block SHALL have port vint, output, W_ACC bits: current accumulator value.
REQ-011 The block SHALL have port phase, output, 2 bits: state code IDLE=00, INTEG=01, DEINT=10, DONE=11.
REQ-012 The block SHALL have port ovf, output, 1 bit: sticky accumulator saturation flag.

Function
REQ-013 The block SHALL implement four states, IDLE, INTEG, DEINT and DONE; all outputs SHALL be registered.
REQ-014 In IDLE, on ch_vm=1 the block SHALL enter INTEG, set vint<=0, clear ovf and set Vint_z<=0; otherwise it SHALL hold with vint=0.
REQ-015 In INTEG, on every cycle the block SHALL set vint<=vint+zero-extended vin, saturating at 2^W_ACC-1; on saturation it SHALL set ovf<=1.
REQ-016 In INTEG, on a cycle with enb_3=1 the block SHALL still perform that cycle's addition and then enter DEINT.
REQ-017 In DEINT, each cycle with vint > step the block SHALL set vint<=vint-step, where step=vref, or step=1 when vref=0.
REQ-018 In DEINT, on a cycle with vint <= step the block SHALL set vint<=0 and Vint_z<=1, and enter DONE.
REQ-019 In DONE, the block SHALL hold Vint_z=1 and vint=0; on ch_vm=1 it SHALL enter IDLE and clear Vint_z.
REQ-020 Vint_z SHALL be 1 only in DONE.
REQ-021 The block SHALL ignore ch_vm in INTEG and DEINT, and SHALL ignore enb_3 outside INTEG.
REQ-022 When ch_vm=1 and enb_3=1 occur in the same IDLE cycle, only the IDLE->INTEG transition SHALL take effect.
REQ-023 vin and vref SHALL be sampled every cycle; changes mid-phase take effect on the next edge.
REQ-024 ovf SHALL remain set through DEINT and DONE until the next IDLE->INTEG transition or reset.
REQ-025 All arithmetic SHALL be unsigned, and vint SHALL never wrap.

Reset
REQ-026 When reset=1 at a rising edge, the block SHALL set phase=IDLE (00), vint=0, Vint_z=0 and ovf=0, regardless of the current state or other inputs.
REQ-027 A reset asserted mid-INTEG or mid-DEINT SHALL abort the measurement, and no Vint_z pulse SHALL follow.

Verification
REQ-028 Normal measurement: vin=20, vref=10, ch_vm pulse, enb_3 on the 8th INTEG cycle -> vint=160 entering DEINT; vint=10 after 15 DEINT cycles; on the 16th DEINT edge vint=0, Vint_z=1, phase=11.
REQ-029 Saturation: W_ACC=12, vin=255, enb_3 on the 17th INTEG cycle -> vint=4080 after 16 cycles, then 4095, ovf=1, and ovf stays 1 through DONE.
REQ-030 Zero reference: vin=3, vref=0, enb_3 on the 2nd INTEG cycle -> vint=6; DEINT steps by 1; Vint_z=1 on the 6th DEINT edge.
REQ-031 Reset mid-DEINT: reset=1 for one cycle at vint=50 -> phase=00, vint=0, Vint_z=0, ovf=0; Vint_z does not rise without a new ch_vm.
REQ-032 Ignored inputs: ch_vm and enb_3 pulses during DEINT -> no state change and no accumulator disturbance.
REQ-033 DONE acknowledge: ch_vm=1 in DONE -> IDLE with Vint_z=0; a second ch_vm=1 -> INTEG with ovf cleared.
